// File: rtl/uart_pkg.sv
// Shared UART receive definitions: frame geometry, field indices and the receiver state encoding.
package uart_pkg;

  localparam int UART_OVERSAMPLE   = 16;
  localparam int UART_FRAME_BITS   = 11;
  localparam int UART_SAMPLE_POINT = 7;

  // Field positions within a received frame (bit 0 arrives first).
  localparam int START_IDX  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_IDX = 9;
  localparam int STOP_IDX   = 10;

  typedef enum logic {
    IDLE,
    RECEIVE
  } rx_state_t;

  function automatic logic [7:0] frame_byte(input logic [UART_FRAME_BITS-1:0] frame);
    return frame[DATA_MSB:DATA_LSB];
  endfunction

  function automatic logic frame_parity(input logic [UART_FRAME_BITS-1:0] frame);
    return frame[PARITY_IDX];
  endfunction

  function automatic logic frame_stop(input logic [UART_FRAME_BITS-1:0] frame);
    return frame[STOP_IDX];
  endfunction

endpackage

// File: rtl/uart_sipo_rx_if.sv
// Serial line in / parallel frame out bundle of the UART receive deserializer.
// frame_err exists only when UART_SIPO_FRAME_ERR_EN is defined.
interface uart_sipo_rx_if #(
  parameter int FRAME_BITS = uart_pkg::UART_FRAME_BITS
);

  logic                  data_tx;
  logic                  active_flag;
  logic                  recieved_flag;
  logic [FRAME_BITS-1:0] data_parll;
`ifdef UART_SIPO_FRAME_ERR_EN
  logic                  frame_err;
`endif

`ifdef UART_SIPO_FRAME_ERR_EN
  modport master (
    output data_tx,
    input  active_flag,
    input  recieved_flag,
    input  data_parll,
    input  frame_err
  );

  modport slave (
    input  data_tx,
    output active_flag,
    output recieved_flag,
    output data_parll,
    output frame_err
  );
`else
  modport master (
    output data_tx,
    input  active_flag,
    input  recieved_flag,
    input  data_parll
  );

  modport slave (
    input  data_tx,
    output active_flag,
    output recieved_flag,
    output data_parll
  );
`endif

endinterface

// File: rtl/uart_line_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the baud_clk domain.
module uart_line_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic baud_clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments let both flops sample their inputs from before the edge,
  // giving a true two-stage pipeline instead of a single flop.
  always_ff @(posedge baud_clk) begin
    if (reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/uart_sipo_rx.sv
// UART receive deserializer: finds a start bit, samples one frame mid-bit and presents it in parallel.
// Optional stop-bit error output is enabled by defining UART_SIPO_FRAME_ERR_EN.
module uart_sipo_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int FRAME_BITS   = UART_FRAME_BITS,
  parameter int SAMPLE_POINT = UART_SAMPLE_POINT
) (
  input logic           baud_clk,
  input logic           reset_n,
  uart_sipo_rx_if.slave bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(FRAME_BITS);

  logic line;

  uart_line_sync #(
    .RESET_VAL(1'b1)
  ) u_line_sync (
    .baud_clk(baud_clk),
    .reset_n (reset_n),
    .din     (bus.data_tx),
    .dout    (line)
  );

  rx_state_t             state_q,  state_d;
  logic [TICK_W-1:0]     tick_q,   tick_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic [FRAME_BITS-2:0] shift_q,  shift_d;
  logic [FRAME_BITS-1:0] parll_q,  parll_d;
  logic                  active_q, active_d;
  logic                  rcvd_q,   rcvd_d;
`ifdef UART_SIPO_FRAME_ERR_EN
  logic                  ferr_q,   ferr_d;
`endif

  logic sample_now;
  logic tick_wrap;
  logic last_bit;
  logic start_bit;

  assign sample_now = (tick_q == TICK_W'(SAMPLE_POINT));
  assign tick_wrap  = (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign last_bit   = (bit_q  == BIT_W'(FRAME_BITS - 1));
  assign start_bit  = (bit_q  == BIT_W'(START_IDX));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parll_d  = parll_q;
    active_d = active_q;
    rcvd_d   = 1'b0;
`ifdef UART_SIPO_FRAME_ERR_EN
    ferr_d   = ferr_q;
`endif

    case (state_q)
      IDLE: begin
        if (!line) begin
          state_d  = RECEIVE;
          tick_d   = '0;
          bit_d    = '0;
          active_d = 1'b1;
        end
      end

      RECEIVE: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) begin
          bit_d = bit_q + 1'b1;
        end

        if (sample_now) begin
          if (last_bit) begin
            // The stop bit goes straight to the output; the shift register only holds earlier bits.
            parll_d  = {line, shift_q};
            rcvd_d   = 1'b1;
            active_d = 1'b0;
            state_d  = IDLE;
`ifdef UART_SIPO_FRAME_ERR_EN
            ferr_d   = ~line;
`endif
          end else if (start_bit && line) begin
            // Line went back high by mid-start-bit: treat it as a glitch and drop the frame.
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            shift_d[bit_q] = line;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (reset_n) begin
      // NOTE: the shift register is reset to the idle-line pattern along with the control state,
      // so a frame cut short by reset can never leak partial bits into a later output.
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      parll_q  <= '1;
      active_q <= 1'b0;
      rcvd_q   <= 1'b0;
`ifdef UART_SIPO_FRAME_ERR_EN
      ferr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parll_q  <= parll_d;
      active_q <= active_d;
      rcvd_q   <= rcvd_d;
`ifdef UART_SIPO_FRAME_ERR_EN
      ferr_q   <= ferr_d;
`endif
    end
  end

  assign bus.active_flag   = active_q;
  assign bus.recieved_flag = rcvd_q;
  assign bus.data_parll    = parll_q;
`ifdef UART_SIPO_FRAME_ERR_EN
  assign bus.frame_err     = ferr_q;
`endif

endmodule

// File: tb/tb_uart_sipo_rx.sv
// Self-checking bench for uart_sipo_rx: directed scenarios plus random frames and glitches,
// scored against a frame-level expectation queue.
module tb_uart_sipo_rx;
  import uart_pkg::*;

  localparam int OS = UART_OVERSAMPLE;
  localparam int FB = UART_FRAME_BITS;

  logic baud_clk = 1'b0;
  logic reset_n;

  int n_checks = 0;
  int n_errors = 0;

  uart_sipo_rx_if #(.FRAME_BITS(FB)) bus ();

  uart_sipo_rx #(
    .OVERSAMPLE  (OS),
    .FRAME_BITS  (FB),
    .SAMPLE_POINT(UART_SAMPLE_POINT)
  ) dut (
    .baud_clk(baud_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 baud_clk = ~baud_clk;

  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] got_q[$];
  logic [FB-1:0] exp_last;
  int            active_rises = 0;
  logic          active_prev  = 1'b0;
`ifdef UART_SIPO_FRAME_ERR_EN
  logic          exp_ferr_q[$];
  logic          got_ferr_q[$];
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observer: records every completed frame as seen on the outputs.
  always @(negedge baud_clk) begin
    if (bus.active_flag === 1'b1 && active_prev === 1'b0) active_rises++;
    active_prev = bus.active_flag;
    if (bus.recieved_flag === 1'b1) begin
      got_q.push_back(bus.data_parll);
      check("done_active_low", {31'd0, bus.active_flag}, 32'd0);
`ifdef UART_SIPO_FRAME_ERR_EN
      got_ferr_q.push_back(bus.frame_err);
`endif
    end
  end

  initial begin
    repeat (40000) @(posedge baud_clk);
    $display("FAIL watchdog expired after 40000 cycles");
    $fatal(1, "watchdog");
  end

  function automatic logic [FB-1:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [FB-1:0] f;
    f                    = '1;
    f[START_IDX]         = 1'b0;
    f[DATA_MSB:DATA_LSB] = d;
    f[PARITY_IDX]        = par;
    f[STOP_IDX]          = stop;
    return f;
  endfunction

  task automatic idle(input int n);
    bus.data_tx = 1'b1;
    repeat (n) @(negedge baud_clk);
  endtask

  // Drives one frame at OS clocks per bit. reset_bit >= 0 aborts with a reset in that bit.
  task automatic send_frame(input logic [FB-1:0] f, input bit check_rise, input int reset_bit);
    for (int i = 0; i < FB; i++) begin
      bus.data_tx = f[i];
      if (i == reset_bit) begin
        repeat (OS / 2) @(negedge baud_clk);
        reset_n = 1'b1;
        @(negedge baud_clk);
        reset_n = 1'b0;
        check("rst_active", {31'd0, bus.active_flag}, 32'd0);
        check("rst_rcvd", {31'd0, bus.recieved_flag}, 32'd0);
        check("rst_parll", 32'(bus.data_parll), 32'h7FF);
        exp_last    = '1;
        bus.data_tx = 1'b1;
        return;
      end else if (i == 0 && check_rise) begin
        repeat (2) @(negedge baud_clk);
        check("rise_early", {31'd0, bus.active_flag}, 32'd0);
        @(negedge baud_clk);
        check("rise_3cyc", {31'd0, bus.active_flag}, 32'd1);
        repeat (OS - 3) @(negedge baud_clk);
      end else if (i == 5) begin
        repeat (OS / 2) @(negedge baud_clk);
        check("active_mid", {31'd0, bus.active_flag}, 32'd1);
        repeat (OS - OS / 2) @(negedge baud_clk);
      end else begin
        repeat (OS) @(negedge baud_clk);
      end
    end
    bus.data_tx = 1'b1;
    exp_q.push_back(f);
    exp_last = f;
`ifdef UART_SIPO_FRAME_ERR_EN
    exp_ferr_q.push_back(~f[STOP_IDX]);
`endif
  endtask

  task automatic glitch(input int len);
    bus.data_tx = 1'b0;
    repeat (len) @(negedge baud_clk);
    bus.data_tx = 1'b1;
    repeat (3 * OS) @(negedge baud_clk);
  endtask

  task automatic score(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_frame"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
`ifdef UART_SIPO_FRAME_ERR_EN
    while (got_ferr_q.size() > 0 && exp_ferr_q.size() > 0)
      check({tag, "_ferr"}, {31'd0, got_ferr_q.pop_front()}, {31'd0, exp_ferr_q.pop_front()});
    got_ferr_q.delete();
    exp_ferr_q.delete();
`endif
    check({tag, "_hold"}, 32'(bus.data_parll), 32'(exp_last));
  endtask

  initial begin
    int            r0;
    logic [7:0]    d;
    logic [FB-1:0] f;

    bus.data_tx = 1'b1;
    reset_n     = 1'b1;
    repeat (2) @(posedge baud_clk);
    @(negedge baud_clk);
    check("reset_active", {31'd0, bus.active_flag}, 32'd0);
    check("reset_rcvd", {31'd0, bus.recieved_flag}, 32'd0);
    check("reset_parll", 32'(bus.data_parll), 32'h7FF);
    reset_n  = 1'b0;
    exp_last = '1;
    idle(4);

    // Nominal: line bits 0,1,0,1,0,1,0,1,0,1,1
    send_frame(make_frame(8'h55, 1'b1, 1'b1), 1'b1, -1);
    idle(8);
    check("nom_word", 32'(bus.data_parll), 32'h6AA);
    check("nom_byte", 32'(frame_byte(bus.data_parll)), 32'h55);
    check("nom_parity", {31'd0, frame_parity(bus.data_parll)}, 32'd1);
    score("nominal");

    // Short low pulse on an idle line
    r0 = active_rises;
    glitch(4);
    check("glitch_rise", 32'(active_rises - r0), 32'd1);
    check("glitch_idle", {31'd0, bus.active_flag}, 32'd0);
    score("glitch");

    // Back-to-back frames with no idle gap
    send_frame(make_frame(8'hA5, ^8'hA5, 1'b1), 1'b0, -1);
    send_frame(make_frame(8'h3C, ^8'h3C, 1'b1), 1'b0, -1);
    idle(8);
    check("b2b_byte", 32'(frame_byte(bus.data_parll)), 32'h3C);
    score("b2b");

    // Reset in the middle of bit 5, then a clean frame
    send_frame(make_frame(8'($urandom), 1'($urandom), 1'b1), 1'b0, 5);
    idle(2 * FB * OS);
    score("reset_drop");
    send_frame(make_frame(8'hC3, ^8'hC3, 1'b1), 1'b0, -1);
    idle(8);
    score("post_reset");

`ifdef UART_SIPO_FRAME_ERR_EN
    send_frame(make_frame(8'h81, 1'b0, 1'b0), 1'b0, -1);
    idle(3 * OS);
    check("ferr_set", {31'd0, bus.frame_err}, 32'd1);
    check("ferr_stop", {31'd0, frame_stop(bus.data_parll)}, 32'd0);
    score("ferr_bad");
    send_frame(make_frame(8'h7E, 1'b0, 1'b1), 1'b0, -1);
    idle(8);
    check("ferr_clear", {31'd0, bus.frame_err}, 32'd0);
    score("ferr_good");
`endif

    // Random traffic: frames with random gaps, interleaved with short glitches
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        glitch($urandom_range(1, 6));
      end else begin
        d = 8'($urandom);
        f = make_frame(d, 1'($urandom), 1'b1);
        send_frame(f, 1'b0, -1);
        idle($urandom_range(0, 24));
      end
      idle(4);
      score("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
